clock_source_sequencer: RTL and testbench

CLOCK_SOURCE_SEQUENCER -- requirements
Module: clock_source_sequencer

---
 rtl/clock_source_pkg.sv | 29 ++
 rtl/source_qualifier.sv | 27 ++
 rtl/clock_source_sequencer.sv | 133 +++++++++++++
 tb/tb_clock_source_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_source_pkg.sv
// Shared types for the clock source sequencer: source codes, mux encoding and FSM states.
package clock_source_pkg;

  localparam int NumSources = 4;

  typedef enum logic [1:0] {
    SrcSma   = 2'd0,
    SrcMac   = 2'd1,
    SrcDcxo1 = 2'd2,
    SrcDcxo2 = 2'd3
  } sourceT;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    SWITCH = 2'd1,
    RUN    = 2'd2
  } seqStateT;

  // One-hot mux selects, ordered {Mux1, Mux2, Mux3, Wiz2}
  function automatic logic [3:0] muxEncode(input sourceT src);
    case (src)
      SrcSma:   return 4'b1000;
      SrcMac:   return 4'b0100;
      SrcDcxo1: return 4'b0010;
      default:  return 4'b0001;
    endcase
  endfunction

endpackage

// File: rtl/source_qualifier.sv
// Declares a source usable once its alive flag has stayed high for HoldoffCycles_Gen cycles.
module source_qualifier #(
  parameter int HoldoffCycles_Gen = 1000
) (
  input  logic SysClk_ClkIn,
  input  logic SysRst_RstIn,
  input  logic Available_DatIn,
  output logic Qualified_DatOut
);

  localparam int CntW = (HoldoffCycles_Gen > 1) ? $clog2(HoldoffCycles_Gen + 1) : 1;
  localparam logic [CntW-1:0] HoldoffLoad = CntW'(HoldoffCycles_Gen);

  logic [CntW-1:0] holdCount;

  // Down-counter that saturates at zero; any low cycle reloads the full holdoff
  always_ff @(posedge SysClk_ClkIn) begin
    if (SysRst_RstIn || !Available_DatIn) begin
      holdCount <= HoldoffLoad;
    end else if (holdCount != '0) begin
      holdCount <= holdCount - CntW'(1);
    end
  end

  assign Qualified_DatOut = (holdCount == '0);

endmodule

// File: rtl/clock_source_sequencer.sv
// Picks a qualified clock source, drives the mux selects and sequences the downstream clock reset.
//   state  | meaning
//   HOLD   | no usable target, downstream clock held in reset, muxes frozen
//   SWITCH | muxes just changed, reset held low while the new clock settles
//   RUN    | settled on the active source, downstream reset released
module clock_source_sequencer
  import clock_source_pkg::*;
#(
  parameter int HoldoffCycles_Gen = 1000,
  parameter int SettleCycles_Gen  = 100
) (
  input  logic        SysClk_ClkIn,
  input  logic        SysRst_RstIn,
  input  logic [3:0]  SourceAvailable_DatIn,
  input  logic [2:0]  Mode_DatIn,
  output logic        ClkMux1Select_EnOut,
  output logic        ClkMux2Select_EnOut,
  output logic        ClkMux3Select_EnOut,
  output logic        ClkWiz2Select_EnOut,
  output logic        ClockRstN_RstOut,
  output logic [1:0]  ActiveSource_DatOut,
  output logic        NoSource_DatOut,
  output logic [15:0] SwitchCount_DatOut
);

  localparam int SetW = (SettleCycles_Gen > 2) ? $clog2(SettleCycles_Gen) : 1;
  localparam logic [SetW-1:0] SettleLoad = SetW'(SettleCycles_Gen - 1);

  logic [NumSources-1:0] qualified;

  for (genvar g = 0; g < NumSources; g++) begin : gQual
    source_qualifier #(.HoldoffCycles_Gen(HoldoffCycles_Gen)) uQual (
      .SysClk_ClkIn     (SysClk_ClkIn),
      .SysRst_RstIn     (SysRst_RstIn),
      .Available_DatIn  (SourceAvailable_DatIn[g]),
      .Qualified_DatOut (qualified[g])
    );
  end

  sourceT target;
  logic   targetValid;

  // Forced modes pin one source; everything else is revertive lowest-index priority
  always_comb begin
    target      = SrcSma;
    targetValid = 1'b0;
    if (Mode_DatIn >= 3'd1 && Mode_DatIn <= 3'd4) begin
      target      = sourceT'(Mode_DatIn[1:0] - 2'd1);
      targetValid = qualified[target];
    end else begin
      for (int i = NumSources - 1; i >= 0; i--) begin
        if (qualified[i]) begin
          target      = sourceT'(i[1:0]);
          targetValid = 1'b1;
        end
      end
    end
  end

  seqStateT        state, stateNext;
  sourceT          activeSrc, activeNext;
  logic [SetW-1:0] settleCount, settleNext;
  logic [15:0]     switchCount, countNext;
  logic            clockRstN, rstNNext;
  logic            loadSwitch;

  always_ff @(posedge SysClk_ClkIn) begin
    if (SysRst_RstIn) begin
      state       <= HOLD;
      activeSrc   <= SrcDcxo2;
      settleCount <= '0;
      switchCount <= '0;
      clockRstN   <= 1'b0;
    end else begin
      state       <= stateNext;
      activeSrc   <= activeNext;
      settleCount <= settleNext;
      switchCount <= countNext;
      clockRstN   <= rstNNext;
    end
  end

  always_comb begin
    stateNext  = state;
    activeNext = activeSrc;
    settleNext = settleCount;
    countNext  = switchCount;
    rstNNext   = 1'b0;
    loadSwitch = 1'b0;
    case (state)
      HOLD: begin
        if (targetValid) loadSwitch = 1'b1;
      end
      SWITCH: begin
        if (!targetValid) begin
          stateNext = HOLD;
        end else if (target != activeSrc) begin
          loadSwitch = 1'b1;
        end else if (settleCount == '0) begin
          stateNext = RUN;
          rstNNext  = 1'b1;
        end else begin
          settleNext = settleCount - SetW'(1);
        end
      end
      RUN: begin
        if (!targetValid) begin
          stateNext = HOLD;
        end else if (target != activeSrc) begin
          loadSwitch = 1'b1;
        end else begin
          rstNNext = 1'b1;
        end
      end
      default: stateNext = HOLD;
    endcase
    // Re-selecting the same source re-runs the settle window but is not a new switch
    if (loadSwitch) begin
      stateNext  = SWITCH;
      activeNext = target;
      settleNext = SettleLoad;
      if (target != activeSrc && switchCount != 16'hFFFF) countNext = switchCount + 16'd1;
    end
  end

  assign {ClkMux1Select_EnOut, ClkMux2Select_EnOut,
          ClkMux3Select_EnOut, ClkWiz2Select_EnOut} = muxEncode(activeSrc);
  assign ClockRstN_RstOut    = clockRstN;
  assign ActiveSource_DatOut = activeSrc;
  assign NoSource_DatOut     = (state == HOLD);
  assign SwitchCount_DatOut  = switchCount;

endmodule

// File: tb/tb_clock_source_sequencer.sv
// Self-checking bench for clock_source_sequencer with a cycle-level behavioural reference model.
module tb_clock_source_sequencer;

  localparam int Holdoff = 4;
  localparam int Settle  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  avail = 4'b0000;
  logic [2:0]  mode = 3'd0;
  logic        mux1, mux2, mux3, wiz2;
  logic        clockRstN, noSource;
  logic [1:0]  activeSrc;
  logic [15:0] switchCount;

  wire [3:0]  muxSel = {mux1, mux2, mux3, wiz2};
  wire [23:0] obs    = {muxSel, activeSrc, clockRstN, noSource, switchCount};

  int checks = 0;
  int failures = 0;

  clock_source_sequencer #(.HoldoffCycles_Gen(Holdoff), .SettleCycles_Gen(Settle)) dut (
    .SysClk_ClkIn          (clk),
    .SysRst_RstIn          (rst),
    .SourceAvailable_DatIn (avail),
    .Mode_DatIn            (mode),
    .ClkMux1Select_EnOut   (mux1),
    .ClkMux2Select_EnOut   (mux2),
    .ClkMux3Select_EnOut   (mux3),
    .ClkWiz2Select_EnOut   (wiz2),
    .ClockRstN_RstOut      (clockRstN),
    .ActiveSource_DatOut   (activeSrc),
    .NoSource_DatOut       (noSource),
    .SwitchCount_DatOut    (switchCount)
  );

  always #5 clk = ~clk;

  // Reference model: per-source run lengths plus a description of where the sequence stands
  int streak[4] = '{0, 0, 0, 0};
  int mActive = 3;
  int mCount = 0;
  int mSettleLeft = 0;
  bit mHolding = 1'b1;
  bit mSwitching = 1'b0;
  bit mRstN = 1'b0;

  function automatic int modelTarget();
    if (mode >= 3'd1 && mode <= 3'd4)
      return (streak[int'(mode) - 1] >= Holdoff) ? int'(mode) - 1 : -1;
    for (int i = 0; i < 4; i++)
      if (streak[i] >= Holdoff) return i;
    return -1;
  endfunction

  function automatic logic [23:0] expBundle();
    logic [3:0] m;
    m = 4'b1000 >> mActive;
    return {m, 2'(mActive), mRstN, mHolding, 16'(mCount)};
  endfunction

  task automatic tick();
    int tgt;
    @(posedge clk);
    tgt = modelTarget();
    if (rst) begin
      mActive = 3; mCount = 0; mHolding = 1'b1; mSwitching = 1'b0; mRstN = 1'b0; mSettleLeft = 0;
    end else if (tgt < 0) begin
      mHolding = 1'b1; mSwitching = 1'b0; mRstN = 1'b0;
    end else if (mHolding || tgt != mActive) begin
      if (tgt != mActive && mCount < 65535) mCount++;
      mActive = tgt; mHolding = 1'b0; mSwitching = 1'b1; mSettleLeft = Settle; mRstN = 1'b0;
    end else if (mSwitching) begin
      mSettleLeft--;
      if (mSettleLeft == 0) begin
        mSwitching = 1'b0; mRstN = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++)
      streak[i] = (rst || !avail[i]) ? 0 : ((streak[i] < 1000) ? streak[i] + 1 : streak[i]);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 3'd0; avail = 4'($urandom);
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (obs !== expBundle()) begin
        failures++; $display("FAIL reset_model cyc %0d: got %h want %h", c, obs, expBundle());
      end
      checks++;
      if (obs !== {4'b0001, 2'd3, 1'b0, 1'b1, 16'd0}) begin
        failures++; $display("FAIL reset_values cyc %0d: got %h want %h", c, obs, {4'b0001, 2'd3, 1'b0, 1'b1, 16'd0});
      end
    end
  endtask

  task automatic test_first_lock();
    rst = 1'b0; mode = 3'd0; avail = 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if (obs !== expBundle()) begin
        failures++; $display("FAIL first_lock_model cyc %0d: got %h want %h", c, obs, expBundle());
      end
      if (c == 4) begin
        checks++;
        if ({muxSel, noSource} !== {4'b0001, 1'b1}) begin
          failures++; $display("FAIL first_lock_still_hold: got %b want %b", {muxSel, noSource}, 5'b00011);
        end
      end
      if (c == 5) begin
        checks++;
        if ({muxSel, clockRstN, switchCount} !== {4'b1000, 1'b0, 16'd1}) begin
          failures++; $display("FAIL first_lock_mux: got %h want %h", {muxSel, clockRstN, switchCount}, {4'b1000, 1'b0, 16'd1});
        end
      end
      if (c == 7 || c == 8) begin
        checks++;
        if (clockRstN !== (c == 8)) begin
          failures++; $display("FAIL first_lock_rstn cyc %0d: got %b want %b", c, clockRstN, (c == 8));
        end
      end
    end
  endtask

  task automatic test_failover();
    avail = 4'b0101;
    for (int c = 1; c <= 11; c++) begin
      if (c == 7) avail = 4'b0100;
      tick();
      checks++;
      if (obs !== expBundle()) begin
        failures++; $display("FAIL failover_model cyc %0d: got %h want %h", c, obs, expBundle());
      end
      if (c == 6 || c == 7) begin
        checks++;
        if ({muxSel, clockRstN} !== {4'b1000, 1'b1}) begin
          failures++; $display("FAIL failover_no_switch cyc %0d: got %b want %b", c, {muxSel, clockRstN}, 5'b10001);
        end
      end
      if (c >= 8) begin
        checks++;
        if ({muxSel, clockRstN, switchCount} !== {4'b0010, (c == 11), 16'd2}) begin
          failures++; $display("FAIL failover_switch cyc %0d: got %h want %h", c, {muxSel, clockRstN, switchCount}, {4'b0010, (c == 11), 16'd2});
        end
      end
    end
  endtask

  task automatic test_revert();
    for (int c = 1; c <= 15; c++) begin
      avail = (c <= 3 || c >= 8) ? 4'b0101 : 4'b0100;
      tick();
      checks++;
      if (obs !== expBundle()) begin
        failures++; $display("FAIL revert_model cyc %0d: got %h want %h", c, obs, expBundle());
      end
      if (c == 11) begin
        checks++;
        if (muxSel !== 4'b0010) begin
          failures++; $display("FAIL revert_too_early: got %b want %b", muxSel, 4'b0010);
        end
      end
      if (c == 12 || c == 15) begin
        checks++;
        if ({muxSel, clockRstN, switchCount} !== {4'b1000, (c == 15), 16'd3}) begin
          failures++; $display("FAIL revert_sma cyc %0d: got %h want %h", c, {muxSel, clockRstN, switchCount}, {4'b1000, (c == 15), 16'd3});
        end
      end
    end
  endtask

  task automatic test_forced();
    mode = 3'd4; avail = 4'b0001;
    for (int c = 1; c <= 10; c++) begin
      if (c == 3) avail = 4'b1001;
      tick();
      checks++;
      if (obs !== expBundle()) begin
        failures++; $display("FAIL forced_model cyc %0d: got %h want %h", c, obs, expBundle());
      end
      if (c == 2) begin
        checks++;
        if ({muxSel, noSource, clockRstN} !== {4'b1000, 1'b1, 1'b0}) begin
          failures++; $display("FAIL forced_hold: got %b want %b", {muxSel, noSource, clockRstN}, 6'b100010);
        end
      end
      if (c == 7 || c == 9 || c == 10) begin
        checks++;
        if ({muxSel, clockRstN, switchCount} !== {4'b0001, (c == 10), 16'd4}) begin
          failures++; $display("FAIL forced_dcxo2 cyc %0d: got %h want %h", c, {muxSel, clockRstN, switchCount}, {4'b0001, (c == 10), 16'd4});
        end
      end
    end
  endtask

  task automatic test_abort();
    mode = 3'd2; avail = 4'b0011;
    for (int c = 1; c <= 13; c++) begin
      if (c == 6) avail = 4'b0001;
      if (c == 8) mode = 3'd0;
      if (c == 12) rst = 1'b1;
      tick();
      checks++;
      if (obs !== expBundle()) begin
        failures++; $display("FAIL abort_model cyc %0d: got %h want %h", c, obs, expBundle());
      end
      if (c == 5) begin
        checks++;
        if ({muxSel, switchCount} !== {4'b0100, 16'd5}) begin
          failures++; $display("FAIL abort_mac_switch: got %h want %h", {muxSel, switchCount}, {4'b0100, 16'd5});
        end
      end
      if (c == 7) begin
        checks++;
        if ({muxSel, noSource, clockRstN} !== {4'b0100, 1'b1, 1'b0}) begin
          failures++; $display("FAIL abort_to_hold: got %b want %b", {muxSel, noSource, clockRstN}, 6'b010010);
        end
      end
      if (c == 11) begin
        checks++;
        if ({muxSel, clockRstN} !== {4'b1000, 1'b1}) begin
          failures++; $display("FAIL abort_run_sma: got %b want %b", {muxSel, clockRstN}, 5'b10001);
        end
      end
      if (c >= 12) begin
        checks++;
        if (obs !== {4'b0001, 2'd3, 1'b0, 1'b1, 16'd0}) begin
          failures++; $display("FAIL abort_reset_in_run cyc %0d: got %h want %h", c, obs, {4'b0001, 2'd3, 1'b0, 1'b1, 16'd0});
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    int idx;
    for (int c = 1; c <= 1500; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        idx = $urandom_range(0, 3);
        avail[idx] = ~avail[idx];
      end
      if ($urandom_range(0, 59) == 0) mode = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 399) == 0);
      tick();
      checks++;
      if (obs !== expBundle()) begin
        failures++; $display("FAIL random_model cyc %0d mode %0d avail %b: got %h want %h", c, mode, avail, obs, expBundle());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_first_lock();
    test_failover();
    test_revert();
    test_forced();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
